// File: rtl/sensor_readout.sv
// Capture side of the delay-line timing sensor: samples the tap chain every clock, decodes the
// thermometer code to a depth and keeps block average, min/max and sticky alarm/bubble flags.
module sensor_readout #(
    parameter int N_TAPS   = 16,
    parameter int W_CNT    = 5,
    parameter int LOG2_AVG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [N_TAPS-1:0] tap_i,
    input  logic [W_CNT-1:0]  thr_i,
    input  logic              clear_i,
    output logic [W_CNT-1:0]  sample_o,
    output logic              sample_vld_o,
    output logic [W_CNT-1:0]  avg_o,
    output logic              avg_vld_o,
    output logic [W_CNT-1:0]  min_o,
    output logic [W_CNT-1:0]  max_o,
    output logic              bubble_o,
    output logic              alarm_o
);

    localparam int W_SUM = W_CNT + LOG2_AVG;
    localparam logic [W_CNT-1:0] DEPTH_FULL = W_CNT'(N_TAPS);

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_e;

    // Returns {bubble, depth}: depth is the index of the first 0 from bit 0, bubble flags any 1 above it.
    function automatic logic [W_CNT:0] decode_taps(input logic [N_TAPS-1:0] taps);
        logic [W_CNT-1:0] depth;
        logic             found;
        logic             bubble;
        depth  = DEPTH_FULL;
        found  = 1'b0;
        bubble = 1'b0;
        for (int i = 0; i < N_TAPS; i++) begin
            if (!found && !taps[i]) begin
                found = 1'b1;
                depth = W_CNT'(i);
            end else if (found && taps[i]) begin
                bubble = 1'b1;
            end
        end
        return {bubble, depth};
    endfunction

    function automatic logic [W_CNT-1:0] block_avg(input logic [W_SUM-1:0] sum,
                                                   input logic [W_CNT-1:0] last);
        logic [W_SUM-1:0] total;
        total = sum + W_SUM'(last);
        return W_CNT'(total >> LOG2_AVG);
    endfunction

    state_e              state_q, state_d;
    logic                warm_q, warm_d;
    logic [N_TAPS-1:0]   tap_q, tap_d;
    logic [W_CNT-1:0]    sample_q, sample_d;
    logic                sample_vld_q, sample_vld_d;
    logic                smp_bubble_q, smp_bubble_d;
    logic [W_SUM-1:0]    sum_q, sum_d;
    logic [LOG2_AVG-1:0] blk_q, blk_d;
    logic [W_CNT-1:0]    avg_q, avg_d;
    logic                avg_vld_q, avg_vld_d;
    logic [W_CNT-1:0]    min_q, min_d;
    logic [W_CNT-1:0]    max_q, max_d;
    logic                bubble_q, bubble_d;
    logic                alarm_q, alarm_d;

    always_comb begin
        state_d      = state_q;
        warm_d       = warm_q;
        sum_d        = sum_q;
        blk_d        = blk_q;
        avg_d        = avg_q;
        avg_vld_d    = 1'b0;
        min_d        = min_q;
        max_d        = max_q;
        bubble_d     = bubble_q;
        alarm_d      = alarm_q;

        // Two enabled cycles flush the tap/sample pipeline before samples count.
        case (state_q)
            WARMUP: begin
                if (ena) begin
                    if (warm_q) begin
                        state_d = RUN;
                        warm_d  = 1'b0;
                    end else begin
                        warm_d  = 1'b1;
                    end
                end else begin
                    warm_d = 1'b0;
                end
            end
            RUN: begin
                if (!ena) begin
                    state_d = WARMUP;
                end
            end
            default: state_d = WARMUP;
        endcase

        // Stage 0 -> 1: raw capture is the measurement itself, then decode.
        tap_d                      = tap_i;
        {smp_bubble_d, sample_d}   = decode_taps(tap_q);
        sample_vld_d               = (state_q == RUN);

        // Stage 1 -> 2: statistics consume the sample currently on sample_o.
        if (clear_i) begin
            min_d    = DEPTH_FULL;
            max_d    = '0;
            bubble_d = 1'b0;
            alarm_d  = 1'b0;
        end

        if (sample_vld_q) begin
            if (blk_q == '1) begin
                avg_d     = block_avg(sum_q, sample_q);
                avg_vld_d = 1'b1;
                sum_d     = '0;
            end else begin
                sum_d     = sum_q + W_SUM'(sample_q);
            end
            blk_d = blk_q + 1'b1;

            if (clear_i) begin
                min_d = sample_q;
                max_d = sample_q;
            end else begin
                if (sample_q < min_q) min_d = sample_q;
                if (sample_q > max_q) max_d = sample_q;
            end

            if (sample_q < thr_i) alarm_d  = 1'b1;
            if (smp_bubble_q)     bubble_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= WARMUP;
            warm_q       <= 1'b0;
            tap_q        <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            smp_bubble_q <= 1'b0;
            sum_q        <= '0;
            blk_q        <= '0;
            avg_q        <= '0;
            avg_vld_q    <= 1'b0;
            min_q        <= DEPTH_FULL;
            max_q        <= '0;
            bubble_q     <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            warm_q       <= warm_d;
            tap_q        <= tap_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            smp_bubble_q <= smp_bubble_d;
            sum_q        <= sum_d;
            blk_q        <= blk_d;
            avg_q        <= avg_d;
            avg_vld_q    <= avg_vld_d;
            min_q        <= min_d;
            max_q        <= max_d;
            bubble_q     <= bubble_d;
            alarm_q      <= alarm_d;
        end
    end

    assign sample_o     = sample_q;
    assign sample_vld_o = sample_vld_q;
    assign avg_o        = avg_q;
    assign avg_vld_o    = avg_vld_q;
    assign min_o        = min_q;
    assign max_o        = max_q;
    assign bubble_o     = bubble_q;
    assign alarm_o      = alarm_q;

endmodule
